// File: rtl/reg_scoreboard_pkg.sv
// Shared types for the register-use scoreboard: instruction layout, opcode set and
// the register-use decode that forwarding logic can reuse.
package reg_scoreboard_pkg;

  localparam int SB_CNT_W = 2;

  typedef enum logic [6:0] {
    OP_LOAD    = 7'b0000011,
    OP_REG_IMM = 7'b0010011,
    OP_AUIPC   = 7'b0010111,
    OP_STORE   = 7'b0100011,
    OP_REG_REG = 7'b0110011,
    OP_LUI     = 7'b0110111,
    OP_BRANCH  = 7'b1100011,
    OP_JALR    = 7'b1100111,
    OP_JAL     = 7'b1101111
  } opcode_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } Insn;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wback;
  } RegUse;

  // Fields an opcode does not use read as register 0, which is never tracked.
  function automatic RegUse decode_reg_use(input Insn insn);
    RegUse u;
    u = '0;
    case (insn.opcode)
      OP_REG_REG: begin
        u.rs1   = insn.rs1;
        u.rs2   = insn.rs2;
        u.rd    = insn.rd;
        u.wback = 1'b1;
      end
      OP_REG_IMM, OP_JALR, OP_LOAD: begin
        u.rs1   = insn.rs1;
        u.rd    = insn.rd;
        u.wback = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        u.rs1 = insn.rs1;
        u.rs2 = insn.rs2;
      end
      OP_JAL, OP_AUIPC, OP_LUI: begin
        u.rd    = insn.rd;
        u.wback = 1'b1;
      end
      default: ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-write counter: one increment and up to two decrements per
// cycle, clamping at zero with an underflow flag, plus a synchronous clear.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             underflow
);

  localparam int XW = CNT_W + 2;
  localparam logic [XW-1:0] MAX = XW'((1 << CNT_W) - 1);

  logic [XW-1:0] up;
  logic [XW-1:0] dec_x;
  logic [XW-1:0] diff;

  // Net the increment against both decrements so same-cycle events cancel.
  always_comb begin
    up         = {2'b00, count} + {{(XW-1){1'b0}}, inc};
    dec_x      = {{CNT_W{1'b0}}, dec};
    diff       = up - dec_x;
    underflow  = 1'b0;
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (up < dec_x) begin
      underflow  = 1'b1;
      count_next = '0;
    end else if (diff > MAX) begin
      count_next = MAX[CNT_W-1:0];
    end else begin
      count_next = diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_next;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-use scoreboard for decode: tracks pending writes per register and stalls
// on busy sources or a saturated destination. SCOREBOARD_WB_BYPASS_EN lets a source
// whose last pending write retires this cycle be read without stalling.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  Insn                i_insn,
  input  logic               i_valid,
  input  logic               i_issue,
  input  logic               i_wb_valid,
  input  logic [4:0]         i_wb_wreg,
  input  logic               i_kill_valid,
  input  logic [4:0]         i_kill_wreg,
  input  logic               i_flush,
  output logic               o_stall,
  output logic [NREGS-1:0]   o_busy,
  output logic               o_err,
  output logic [CNT_W+4:0]   o_inflight
);

  localparam int IW = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  RegUse            ru;
  logic [CNT_W-1:0] cnt      [NREGS];
  logic [CNT_W-1:0] cnt_next [NREGS];
  logic [NREGS-1:0] under;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             rd_sat;
  logic             issue_ok;
  logic [IW-1:0]    sum;

  assign ru = decode_reg_use(i_insn);

  always_comb begin
    rs1_busy = (ru.rs1 != 5'd0) && (cnt[ru.rs1] != '0);
    rs2_busy = (ru.rs2 != 5'd0) && (cnt[ru.rs2] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // The register file writes through, so a retiring last writer is readable now.
    if (cnt[ru.rs1] == CNT_ONE && i_wb_valid && i_wb_wreg == ru.rs1) rs1_busy = 1'b0;
    if (cnt[ru.rs2] == CNT_ONE && i_wb_valid && i_wb_wreg == ru.rs2) rs2_busy = 1'b0;
`endif
    rd_sat   = ru.wback && (ru.rd != 5'd0) && (cnt[ru.rd] == CNT_MAX);
    o_stall  = i_valid && (rs1_busy || rs2_busy || rd_sat);
    issue_ok = i_issue && i_valid && !o_stall && ru.wback && (ru.rd != 5'd0);
  end

  assign cnt[0]      = '0;
  assign cnt_next[0] = '0;
  assign under[0]    = 1'b0;
  assign o_busy[0]   = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic [1:0] dec;
    assign dec = {1'b0, i_wb_valid && (i_wb_wreg == 5'(r))}
               + {1'b0, i_kill_valid && (i_kill_wreg == 5'(r))};

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (i_flush),
      .inc        (issue_ok && (ru.rd == 5'(r))),
      .dec        (dec),
      .count      (cnt[r]),
      .count_next (cnt_next[r]),
      .underflow  (under[r])
    );

    assign o_busy[r] = (cnt[r] != '0);
  end

  always_comb begin
    sum = '0;
    for (int r = 0; r < NREGS; r++) sum = sum + IW'(cnt_next[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err      <= 1'b0;
      o_inflight <= '0;
    end else begin
      o_err      <= o_err | (|under) | (i_issue && o_stall && !i_flush);
      o_inflight <= sum;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a count-per-register model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] insn = '0;
  logic        valid = 1'b0, issue = 1'b0, wb_valid = 1'b0, kill_valid = 1'b0, flush = 1'b0;
  logic [4:0]  wb_wreg = '0, kill_wreg = '0;
  logic        stall, err;
  logic [31:0] busy;
  logic [6:0]  inflight;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt [32];
  bit m_err = 1'b0;

  reg_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_insn       (insn),
    .i_valid      (valid),
    .i_issue      (issue),
    .i_wb_valid   (wb_valid),
    .i_wb_wreg    (wb_wreg),
    .i_kill_valid (kill_valid),
    .i_kill_wreg  (kill_wreg),
    .i_flush      (flush),
    .o_stall      (stall),
    .o_busy       (busy),
    .o_err        (err),
    .o_inflight   (inflight)
  );

  always #5 clk = ~clk;

  function automatic void bench_decode(input logic [31:0] w, output int rs1, output int rs2,
                                       output int rd, output bit wbk);
    rs1 = 0; rs2 = 0; rd = 0; wbk = 1'b0;
    case (w[6:0])
      7'h33:             begin rs1 = int'(w[19:15]); rs2 = int'(w[24:20]); rd = int'(w[11:7]); wbk = 1'b1; end
      7'h13, 7'h67, 7'h03: begin rs1 = int'(w[19:15]); rd = int'(w[11:7]); wbk = 1'b1; end
      7'h63, 7'h23:      begin rs1 = int'(w[19:15]); rs2 = int'(w[24:20]); end
      7'h6F, 7'h17, 7'h37: begin rd = int'(w[11:7]); wbk = 1'b1; end
      default: ;
    endcase
  endfunction

  function automatic bit src_busy(input int rs);
    bit b;
    b = (rs != 0) && (m_cnt[rs] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (m_cnt[rs] == 1 && wb_valid && int'(wb_wreg) == rs) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic bit model_stall();
    int rs1, rs2, rd;
    bit wbk;
    bench_decode(insn, rs1, rs2, rd, wbk);
    return valid && (src_busy(rs1) || src_busy(rs2) || (wbk && rd != 0 && m_cnt[rd] == 3));
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic int model_inflight();
    int s;
    s = 0;
    for (int r = 0; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  task automatic model_dec(input int r);
    if (r == 0) return;
    if (m_cnt[r] == 0) m_err = 1'b1;
    else m_cnt[r] = m_cnt[r] - 1;
  endtask

  task automatic model_step();
    int rs1, rs2, rd;
    bit wbk, st;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      return;
    end
    st = model_stall();
    bench_decode(insn, rs1, rs2, rd, wbk);
    if (issue && st) m_err = 1'b1;
    else if (issue && valid && wbk && rd != 0) m_cnt[rd] = m_cnt[rd] + 1;
    if (wb_valid)   model_dec(int'(wb_wreg));
    if (kill_valid) model_dec(int'(kill_wreg));
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_err = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_output("model busy", busy, model_busy());
      check_output("model stall", 32'(stall), 32'(model_stall()));
      check_output("model inflight", 32'(inflight), 32'(model_inflight()));
      check_output("model err", 32'(err), 32'(m_err));
    end
  end

  task automatic apply_stimulus(input logic [31:0] w, input logic v, input logic iss,
                                input logic wv, input logic [4:0] wr,
                                input logic kv, input logic [4:0] kr, input logic fl);
    @(posedge clk);
    #1;
    insn = w; valid = v; issue = iss;
    wb_valid = wv; wb_wreg = wr; kill_valid = kv; kill_wreg = kr; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  localparam logic [31:0] ADDI_X5  = 32'h00500293;
  localparam logic [31:0] ADD_DEP5 = 32'h00128333;
  localparam logic [31:0] ADDI_X0  = 32'h00100013;
  localparam logic [31:0] JAL_X0   = 32'h0000006F;
  localparam logic [31:0] ADDI_X7  = 32'h00100393;
  localparam logic [31:0] ADDI_X9  = 32'h00100493;
  localparam logic [31:0] ADDI_X3  = 32'h00100193;
  localparam logic [31:0] ADDI_X4  = 32'h00100213;
  localparam logic [31:0] ADDI_X8  = 32'h00100413;

  initial begin
    #12 rst_n = 1'b1;
    idle();
    check_output("reset busy", busy, 32'h0);
    check_output("reset inflight", 32'(inflight), 32'd0);

    // Illegal issue while stalled sets err and records nothing.
    apply_stimulus(ADDI_X5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    apply_stimulus(ADD_DEP5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check_output("dep stall", 32'(stall), 32'd1);
    idle();
    check_output("illegal issue err", 32'(err), 32'd1);
    check_output("illegal issue busy", busy, 32'h0000_0020);

    // Asynchronous reset mid-cycle with x5 still pending.
    apply_stimulus(ADD_DEP5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check_output("pre-reset stall", 32'(stall), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("async reset busy", busy, 32'h0);
    check_output("async reset stall", 32'(stall), 32'd0);
    check_output("async reset inflight", 32'(inflight), 32'd0);
    check_output("async reset err", 32'(err), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // RAW dependency on x5 and its release.
    apply_stimulus(ADDI_X5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    apply_stimulus(ADD_DEP5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check_output("x5 busy", busy, 32'h0000_0020);
    check_output("x5 stall", 32'(stall), 32'd1);
    apply_stimulus(ADD_DEP5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    check_output("wb-cycle stall", 32'(stall), 32'd0);
`else
    check_output("wb-cycle stall", 32'(stall), 32'd1);
`endif
    apply_stimulus(ADD_DEP5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check_output("post-wb stall", 32'(stall), 32'd0);
    check_output("post-wb busy", busy, 32'h0);

    // Writes to x0 are never tracked.
    apply_stimulus(ADDI_X0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();
    check_output("addi x0 inflight", 32'(inflight), 32'd0);
    apply_stimulus(JAL_X0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();
    check_output("jal x0 busy", busy, 32'h0);
    check_output("jal x0 inflight", 32'(inflight), 32'd0);

    // Saturate x7 with three writers.
    for (int i = 0; i < 3; i++)
      apply_stimulus(ADDI_X7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    apply_stimulus(ADDI_X7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check_output("x7 saturated stall", 32'(stall), 32'd1);
    check_output("x7 inflight", 32'(inflight), 32'd3);
    apply_stimulus(ADDI_X7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    check_output("x7 wb-cycle stall", 32'(stall), 32'd1);
    apply_stimulus(ADDI_X7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check_output("x7 unsat stall", 32'(stall), 32'd0);
    check_output("x7 still busy", busy, 32'h0000_0080);
    check_output("x7 inflight 2", 32'(inflight), 32'd2);
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    idle();
    check_output("x7 drained", 32'(inflight), 32'd0);

    // Netting on x9, then underflow.
    apply_stimulus(ADDI_X9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    apply_stimulus(ADDI_X9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    idle();
    check_output("x9 net busy", busy, 32'h0000_0200);
    check_output("x9 net inflight", 32'(inflight), 32'd1);
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    idle();
    check_output("x9 killed", 32'(inflight), 32'd0);
    check_output("x9 no err yet", 32'(err), 32'd0);
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    idle();
    check_output("x9 underflow err", 32'(err), 32'd1);
    check_output("x9 underflow busy", busy, 32'h0);

    // Flush overrides a same-cycle issue.
    apply_stimulus(ADDI_X3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    apply_stimulus(ADDI_X4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    apply_stimulus(ADDI_X8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    check_output("pre-flush busy", busy, 32'h0000_0018);
    idle();
    check_output("flush busy", busy, 32'h0);
    check_output("flush inflight", 32'(inflight), 32'd0);
    check_output("flush keeps err", 32'(err), 32'd1);

    idle();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-use scoreboard for the in-order RISC-V pipeline.
- Decode issues an instruction with a destination register, which increments that register's pending-write counter. Writeback retires it and decrements the counter. Squash cancels it and decrements the counter.
- Decode queries the scoreboard with its current instruction and stalls on any pending source, so decode no longer inspects every stage's signals.

Parameters:
- NREGS, 32, number of architectural registers (index 0 hardwired zero, never tracked).
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2**CNT_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_insn  in  32  decode-stage instruction (Insn type) to check and, on issue, record
- i_valid  in  1  i_insn is a real instruction
- i_issue  in  1  decode advances i_insn this cycle; legal only when o_stall=0
- i_wb_valid  in  1  writeback retires a register write this cycle
- i_wb_wreg  in  5  register written by the retiring instruction
- i_kill_valid  in  1  a squashed in-flight instruction with wback=1 is cancelled
- i_kill_wreg  in  5  its destination register
- i_flush  in  1  clear all pending state (trap/redirect with pipeline drained)
- o_stall  out  1  combinational: i_valid and (a source is busy or the destination counter is saturated)
- o_busy  out  NREGS  bit r = counter[r]!=0
- o_err  out  1  sticky: decrement of a zero counter, or i_issue while o_stall
- o_inflight  out  CNT_W+5  total pending writes across all registers

Behaviour:
- Reset (rst_n=0, asynchronous): all counters=0, o_busy=0, o_stall=0, o_err=0, o_inflight=0.
- Field decode from i_insn.opcode:
  - RegReg: rs1, rs2, rd, wback=1.
  - RegImm/Jalr/Load: rs1, rd, wback=1.
  - Branch/Store: rs1, rs2, wback=0.
  - Jal/Auipc/Lui: rd, wback=1.
  - Other opcodes: no rs1, rs2 or rd; wback=0.
  - Unused sources and rd read as 0.
- Source busy: rsN!=0 and counter[rsN]!=0.
- Saturation stall: wback=1, rd!=0, counter[rd]=2**CNT_W-1.
- Issue (i_issue=1, i_valid=1, o_stall=0, wback=1, rd!=0): counter[rd] increments at the clock edge. Visible in o_busy/o_stall the next cycle (1-cycle latency).
- Writeback and kill each decrement counter for their register; register 0 is ignored.
- Same-register events in one cycle net out: issue+wb leaves the counter unchanged; wb+kill decrements by 2.
- Decrement of a zero counter: counter stays 0, o_err set.
- i_issue while o_stall=1: ignored, o_err set.
- i_flush: all counters go to 0 next edge. Issue/wb/kill in the same cycle are ignored. o_err is kept.
- o_err clears only on reset.
- o_inflight = registered sum of the counters, updated in the same edge as the counters.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: a source is treated as not busy when counter[rsN]=1 and i_wb_valid with i_wb_wreg=rsN in the same cycle. This relies on write-through in the register file and saves one stall cycle.
- Undefined: busy is computed only from registered counters; the stall releases the cycle after writeback.

Decomposition:
- Common package additions:
  - RegUse struct {rs1, rs2, rd, wback}.
  - Function decode_reg_use(Insn) implementing the opcode table above; reusable by forwarding logic.
  - Constant SB_CNT_W.
- One sub-module, sb_counter: a CNT_W up/down counter with inc and dec (0..2 decrements), an underflow flag, clear, and async reset. Instantiated NREGS-1 times.

Test Plan:
- Reset: rst_n pulsed low mid-operation with counters nonzero -> same cycle o_busy=0, o_stall=0, o_inflight=0, o_err=0.
- Issue addi x5,x0,5 (0x00500293); next cycle query add x6,x5,x1 (0x00128333) -> o_busy[5]=1, o_stall=1.
  - wb x5, no bypass -> o_stall=0 the following cycle.
  - wb x5, with SCOREBOARD_WB_BYPASS_EN -> o_stall=0 in the wb cycle.
- Issue addi x0,x0,1 (0x00100013) -> o_busy stays 0, o_inflight=0. Jal x0 likewise.
- Issue 3 writes to x7 (CNT_W=2) -> a 4th writer to x7 sees o_stall=1 with no source dependence. One wb -> o_stall=0 next cycle, o_busy[7] still 1.
- Issue to x9 plus wb x9 in the same cycle with counter=1 -> counter stays 1. kill x9 -> 0. A further wb x9 -> o_err=1, counter 0.
- Counters nonzero on x3 and x4, i_flush together with i_issue to x8 -> next cycle o_busy=0, o_inflight=0.
